carry_bypass_seq: RTL and testbench
===================================

CARRY_BYPASS_SEQ -- requirements
Module: carry_bypass_seq

Interface
REQ-001 SHALL have parameter SLICES, default 4: number of 8-bit slices; operand width W = 8*SLICES.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port A, input, W: operand A, sampled on input acceptance.
REQ-005 SHALL have port B, input, W: operand B, sampled on input acceptance.
REQ-006 SHALL have port Cin, input, 1: carry into slice 0, sampled on input acceptance.
REQ-007 SHALL have port in_valid, input, 1: operands valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept operands.
REQ-009 SHALL have port Sum, output, W: registered result.
REQ-010 SHALL have port Cout, output, 1: registered carry out of the top slice.
REQ-011 SHALL have port out_valid, output, 1: Sum and Cout valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port Bypass_cnt, output, 4, when BYPASS_STATS_EN is defined: number of bypassed slices in the current result.

Function
REQ-014 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-015 In IDLE: in_ready=1 and out_valid=0; in_valid=1 SHALL latch A, B and Cin, clear slice index k to 0, and enter RUN.
REQ-016 In RUN, each cycle SHALL process slice k, with a = A[8k+7:8k], b = B[8k+7:8k], c = running carry.
REQ-017 The slice sum SHALL be a+b+c mod 256, written to Sum[8k+7:8k].
REQ-018 Block propagate SHALL be P = AND-reduce(a XOR b), meaning all 8 bits propagate.
REQ-019 If P=1, the next carry SHALL be c (bypass path); otherwise it SHALL be the ripple carry out of the slice; both paths SHALL give the same value.
REQ-020 The running carry SHALL update to that next carry and k SHALL increment; after slice SLICES-1, Cout SHALL get the final carry and the state SHALL go to DONE.
REQ-021 Latency SHALL be exactly SLICES+1 cycles from the acceptance edge to the first cycle out_valid=1 (5 cycles at default).
REQ-022 In DONE: out_valid=1 and in_ready=0; Sum and Cout SHALL hold stable until out_ready=1.
REQ-023 out_ready=1 in DONE SHALL return the state to IDLE on that edge; no back-to-back acceptance in the same cycle.
REQ-024 in_valid SHALL be ignored in RUN and DONE; out_ready SHALL be ignored outside DONE.
REQ-025 The carry chain SHALL wrap modulo 2^W; overflow appears only on Cout.

Reset
REQ-026 rst_n=0 SHALL immediately force: state=IDLE, Sum=0, Cout=0, out_valid=0, in_ready=1, k=0, running carry=0, Bypass_cnt=0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no output pulse; the first acceptance after deassertion SHALL behave as from power-up.

Configuration
REQ-028 When macro BYPASS_STATS_EN is defined, Bypass_cnt SHALL clear on acceptance and increment for each slice with P=1; it SHALL hold in DONE.
REQ-029 When BYPASS_STATS_EN is undefined, the Bypass_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Scenario: A=0x0000_00FF, B=0x0000_0001, Cin=0 -> Sum=0x0000_0100, Cout=0, out_valid on cycle 5, Bypass_cnt=0.
REQ-031 Scenario: A=0xFFFF_FFFF, B=0x0000_0000, Cin=1 -> Sum=0x0000_0000, Cout=1, Bypass_cnt=4 (all slices bypass).
REQ-032 Scenario: A=0x5555_5555, B=0xAAAA_AAAA, Cin=0 -> Sum=0xFFFF_FFFF, Cout=0, Bypass_cnt=4.
REQ-033 Scenario: hold out_ready=0 for 10 cycles in DONE while toggling in_valid -> Sum stable, in_ready=0, no new capture.
REQ-034 Scenario: rst_n pulsed low during RUN slice 2 -> all outputs reset immediately, no out_valid; next operation 0x1+0x1 -> Sum=0x2.
REQ-035 Scenario: 1000 random operand pairs, back-to-back with out_ready=1 -> Sum and Cout match A+B+Cin; acceptances spaced SLICES+2 cycles apart.

Source files
------------

// File: rtl/carry_bypass_seq.sv
// Sequential carry-bypass adder: one 8-bit slice per cycle, with a valid/ready handshake on both sides.
// Optional macro BYPASS_STATS_EN adds the Bypass_cnt output (count of bypassed slices per result).
module carry_bypass_seq #(
  parameter int SLICES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*SLICES-1:0]   A,
  input  logic [8*SLICES-1:0]   B,
  input  logic                  Cin,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [8*SLICES-1:0]   Sum,
  output logic                  Cout,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef BYPASS_STATS_EN
  ,
  output logic [3:0]            Bypass_cnt
`endif
);

  localparam int W  = 8 * SLICES;
  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [KW-1:0]   r_k;
  logic            r_c;
  logic            r_cout;
  logic            r_out_valid;
  logic            r_in_ready;
`ifdef BYPASS_STATS_EN
  logic [3:0]      r_bcnt;
`endif

  logic [7:0]      w_a;
  logic [7:0]      w_b;
  logic [7:0]      w_s;
  logic            w_rc;
  logic            w_p;
  logic            w_nc;
  logic            w_last;

  assign w_a = r_a[{r_k, 3'b000} +: 8];
  assign w_b = r_b[{r_k, 3'b000} +: 8];
  assign {w_rc, w_s} = {1'b0, w_a} + {1'b0, w_b} + {8'b0, r_c};
  // When every bit propagates, the carry out equals the carry in, so skip the ripple.
  assign w_p    = &(w_a ^ w_b);
  assign w_nc   = w_p ? r_c : w_rc;
  assign w_last = (r_k == KW'(SLICES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_k         <= '0;
      r_c         <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
`ifdef BYPASS_STATS_EN
      r_bcnt      <= 4'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= A;
            r_b        <= B;
            r_c        <= Cin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
`ifdef BYPASS_STATS_EN
            r_bcnt     <= 4'd0;
`endif
          end
        end
        RUN: begin
          r_sum[{r_k, 3'b000} +: 8] <= w_s;
          r_c <= w_nc;
`ifdef BYPASS_STATS_EN
          r_bcnt <= r_bcnt + {3'b000, w_p};
`endif
          if (w_last) begin
            r_k         <= '0;
            r_cout      <= w_nc;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
`ifdef BYPASS_STATS_EN
  assign Bypass_cnt = r_bcnt;
`endif

endmodule

// File: tb/tb_carry_bypass_seq.sv
// Randomized self-checking bench for carry_bypass_seq against an arithmetic reference model.
module tb_carry_bypass_seq;

  localparam int SLICES = 4;
  localparam int W      = 8 * SLICES;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  A, B;
  logic          Cin, in_valid, out_ready;
  logic          in_ready, Cout, out_valid;
  logic [W-1:0]  Sum;
`ifdef BYPASS_STATS_EN
  logic [3:0]    Bypass_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  carry_bypass_seq #(.SLICES(SLICES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef BYPASS_STATS_EN
    ,
    .Bypass_cnt(Bypass_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i += 32) r = (r << 32) | W'($urandom);
    return r;
  endfunction

  // Number of byte slices whose eight bit pairs all differ.
  function automatic int bypass_model(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [7:0] x;
    n = 0;
    for (int s = 0; s < SLICES; s++) begin
      x = 8'((a >> (8 * s)) ^ (b >> (8 * s)));
      if (x == 8'hFF) n++;
    end
    return n;
  endfunction

  // Caller is at a negedge; returns at the negedge after the result is released.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold, output int acc_cyc);
    logic [W:0] exp;
    int n;
    int lat;
    exp     = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    acc_cyc = -1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    A = a; B = b; Cin = cin; in_valid = 1'b1;
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    A = rnd(); B = rnd(); Cin = ~cin;
    check("busy_in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, SLICES);
    if (!out_valid) return;
    check("sum", Sum, exp[W-1:0]);
    check("cout", Cout, exp[W]);
    check("done_in_ready", in_ready, 0);
`ifdef BYPASS_STATS_EN
    check("bypass_cnt", Bypass_cnt, bypass_model(a, b));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      A = rnd(); B = rnd();
      @(negedge clk);
      check("hold_sum", Sum, exp[W-1:0]);
      check("hold_cout", Cout, exp[W]);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev;
    logic [W-1:0] ra, rb;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef BYPASS_STATS_EN
    check("rst_bypass", Bypass_cnt, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, acc);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, acc);
    run_op(32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 0, acc);
    run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 10, acc);

    // Abort while slice 2 is being processed.
    A = 32'h8181_8181; B = 32'h0101_0101; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sum", Sum, 0);
    check("abort_cout", Cout, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
`ifdef BYPASS_STATS_EN
    check("abort_bypass", Bypass_cnt, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0, acc);

    prev = -1;
    out_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ra = rnd();
      rb = ($urandom_range(0, 3) == 0) ? ~ra : rnd();
      run_op(ra, rb, 1'($urandom_range(0, 1)), 0, acc);
      if (prev >= 0) check("spacing", acc - prev, SLICES + 2);
      prev = acc;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
